// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer that fetches from a synchronous ROM and drives an external 8-bit ALU.
// Optional feature: define ALU_SEQ_LDI_EN to enable ldi (op 11) through the IMM state.

module alu_seq (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] alu_ra,
  output logic [7:0] alu_rb,
  output logic [3:0] alu_op,
  input  logic [9:0] alu_out,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       flag_z,
  output logic       flag_c,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_WAIT_IN  = 3'd3,
    S_WAIT_OUT = 3'd4,
`ifdef ALU_SEQ_LDI_EN
    S_IMM      = 3'd5,
`endif
    S_HALT     = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_OUT  = 4'd6;
  localparam logic [3:0] OP_IN   = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
`ifdef ALU_SEQ_LDI_EN
  localparam logic [3:0] OP_LDI  = 4'd11;
`endif
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic       halted_q, halted_d;
`ifdef ALU_SEQ_LDI_EN
  logic       imm_phase_q, imm_phase_d;
`endif

  logic [3:0] op;
  logic [1:0] a_idx;
  logic [1:0] b_idx;

  assign op    = ir_q[7:4];
  assign a_idx = ir_q[3:2];
  assign b_idx = ir_q[1:0];

  assign imem_addr = pc_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign halted    = halted_q;

  // State register; reset drops any pending handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= 8'd0;
      ir_q        <= 8'd0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      halted_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 8'd0;
      end
`ifdef ALU_SEQ_LDI_EN
      imm_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      z_q         <= z_d;
      c_q         <= c_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      halted_q    <= halted_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
`ifdef ALU_SEQ_LDI_EN
      imm_phase_q <= imm_phase_d;
`endif
    end
  end

  // Next-state, register-file and flag update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    z_d         = z_q;
    c_d         = c_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    halted_d    = halted_q;
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end
`ifdef ALU_SEQ_LDI_EN
    imm_phase_d = imm_phase_q;
`endif

    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d    = imem_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR: begin
            regs_d[a_idx] = alu_out[7:0];
            z_d           = alu_out[9];
            c_d           = alu_out[8];
          end
          OP_OUT: begin
            // Output data is captured once so it stays stable while the sink stalls.
            out_valid_d = 1'b1;
            out_data_d  = regs_q[a_idx];
            state_d     = S_WAIT_OUT;
          end
          OP_IN: begin
            in_ready_d = 1'b1;
            state_d    = S_WAIT_IN;
          end
          OP_MOV: begin
            regs_d[a_idx] = alu_out[7:0];
          end
          OP_JZ: begin
            if (z_q) begin
              pc_d = regs_q[b_idx];
            end else begin
              pc_d = pc_q;
            end
          end
          OP_JMP: begin
            pc_d = regs_q[b_idx];
          end
`ifdef ALU_SEQ_LDI_EN
          OP_LDI: begin
            imm_phase_d = 1'b0;
            state_d     = S_IMM;
          end
`endif
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: begin
            state_d = S_FETCH;
          end
        endcase
      end
      S_WAIT_IN: begin
        if (in_valid && in_ready_q) begin
          regs_d[a_idx] = alu_out[7:0];
          in_ready_d    = 1'b0;
          state_d       = S_FETCH;
        end else begin
          state_d = S_WAIT_IN;
        end
      end
      S_WAIT_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_data_d  = 8'd0;
          state_d     = S_FETCH;
        end else begin
          state_d = S_WAIT_OUT;
        end
      end
`ifdef ALU_SEQ_LDI_EN
      S_IMM: begin
        // First cycle presents the immediate's address; the ROM answers one cycle later.
        if (!imm_phase_q) begin
          imm_phase_d = 1'b1;
        end else begin
          regs_d[a_idx] = imem_data;
          pc_d          = pc_q + 8'd1;
          imm_phase_d   = 1'b0;
          state_d       = S_FETCH;
        end
      end
`endif
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // ALU operand/opcode drive; idle cycles present a quiet nop.
  always_comb begin
    if (state_q == S_EXEC || state_q == S_WAIT_IN || state_q == S_WAIT_OUT) begin
      alu_op = op;
      alu_ra = regs_q[a_idx];
      alu_rb = (op == OP_IN) ? in_data : regs_q[b_idx];
    end else begin
      alu_op = 4'd0;
      alu_ra = 8'd0;
      alu_rb = 8'd0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed programs plus random straight-line programs
// checked against an instruction-level reference model.

module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] alu_ra, alu_rb;
  logic [3:0] alu_op;
  logic [9:0] alu_out;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       flag_z, flag_c, halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rom [256];
  logic [7:0] in_vals [32];
  int         in_dly [32];
  int         out_dly [32];
  logic [7:0] exp_out [$];
  int         exp_cyc, exp_z, exp_c, exp_pc;
  int         in_idx, in_cnt, out_idx, out_cnt;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_op(alu_op), .alu_out(alu_out),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
  );

  // Synchronous instruction ROM
  always @(posedge clk) imem_data <= rom[imem_addr];

  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    case (op)
      4'd1:       t = {1'b0, a} + {1'b0, b};
      4'd2:       t = {1'b0, a} - {1'b0, b};
      4'd3:       t = {1'b0, ~(a & b)};
      4'd4:       t = {a, 1'b0};
      4'd5:       t = {a[0], 1'b0, a[7:1]};
      4'd7, 4'd8: t = {1'b0, b};
      default:    t = {1'b0, a};
    endcase
    return {(t[7:0] == 8'd0), t};
  endfunction

  always_comb alu_out = alu_fn(alu_op, alu_ra, alu_rb);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ins(input int op, input int a, input int b);
    return 8'((op % 16) * 16 + (a % 4) * 4 + (b % 4));
  endfunction

  // Environment: input source and output sink with per-transfer delays
  always @(negedge clk) begin
    if (rst) begin
      in_valid = 1'b0; out_ready = 1'b0;
      in_idx = 0; in_cnt = 0; out_idx = 0; out_cnt = 0;
      in_data = 8'($urandom);
    end else begin
      if (in_valid) begin
        if (!in_ready) begin
          in_valid = 1'b0; in_idx++; in_cnt = 0; in_data = 8'($urandom);
        end
      end else if (in_ready) begin
        if (in_cnt >= in_dly[in_idx % 32]) begin
          in_valid = 1'b1; in_data = in_vals[in_idx % 32];
        end else begin
          in_cnt++; in_data = 8'($urandom);
        end
      end else begin
        in_data = 8'($urandom);
      end
      if (out_valid) begin
        if (out_idx < exp_out.size()) check("out_data", out_data, exp_out[out_idx]);
        else check("out_extra", out_idx, exp_out.size());
        if (out_cnt >= out_dly[out_idx % 32]) out_ready = 1'b1;
        else out_cnt++;
      end else if (out_ready) begin
        out_ready = 1'b0; out_idx++; out_cnt = 0;
      end
    end
  end

  // Instruction-level reference model
  task automatic model();
    int r [4];
    int pc, ii, oi, op, a, b, w, s;
    bit done;
    for (int i = 0; i < 4; i++) r[i] = 0;
    pc = 0; ii = 0; oi = 0; done = 0;
    exp_z = 0; exp_c = 0; exp_cyc = 0; exp_pc = 0;
    exp_out.delete();
    for (int step = 0; step < 2000 && !done; step++) begin
      w = int'(rom[pc]);
      pc = (pc + 1) % 256;
      op = w / 16; a = (w / 4) % 4; b = w % 4;
      exp_cyc += 3;
      case (op)
        1: begin s = r[a] + r[b]; exp_c = int'(s > 255); r[a] = s % 256; end
        2: begin exp_c = int'(r[a] < r[b]); r[a] = (r[a] - r[b] + 256) % 256; end
        3: begin exp_c = 0; r[a] = 255 - (r[a] & r[b]); end
        4: begin s = r[a] * 2; exp_c = int'(s > 255); r[a] = s % 256; end
        5: begin exp_c = r[a] % 2; r[a] = r[a] / 2; end
        6: begin exp_out.push_back(8'(r[a])); exp_cyc += 1 + out_dly[oi % 32]; oi++; end
        7: begin r[a] = int'(in_vals[ii % 32]); exp_cyc += 1 + in_dly[ii % 32]; ii++; end
        8: r[a] = r[b];
        9: if (exp_z != 0) pc = r[b];
        10: pc = r[b];
`ifdef ALU_SEQ_LDI_EN
        11: begin r[a] = int'(rom[pc]); pc = (pc + 1) % 256; exp_cyc += 2; end
`endif
        15: begin done = 1; exp_pc = pc; end
        default: ;
      endcase
      if (op >= 1 && op <= 5) exp_z = int'(r[a] == 0);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    for (int i = 0; i < 32; i++) begin
      in_vals[i] = 8'd0; in_dly[i] = 0; out_dly[i] = 0;
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check({name, "/rst_addr"}, imem_addr, 0);
    check({name, "/rst_outv"}, out_valid, 0);
    check({name, "/rst_inrdy"}, in_ready, 0);
    check({name, "/rst_halt"}, halted, 0);
    check({name, "/rst_flags"}, {flag_z, flag_c}, 0);
    check({name, "/rst_alu"}, {alu_op, alu_ra, alu_rb}, 0);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_body(input string name);
    int n;
    n = 0;
    while (n < 4000) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (halted) break;
    end
    check({name, "/halted"}, halted, 1);
    check({name, "/cycles"}, n, exp_cyc);
    check({name, "/flag_z"}, flag_z, exp_z);
    check({name, "/flag_c"}, flag_c, exp_c);
    check({name, "/out_count"}, out_idx, exp_out.size());
    repeat (4) @(negedge clk);
    check({name, "/pc_frozen"}, imem_addr, exp_pc);
    check({name, "/halt_hold"}, halted, 1);
  endtask

  task automatic run_prog(input string name);
    model();
    do_reset(name);
    run_body(name);
  endtask

  initial begin
    int p;
    // Reset in the middle of a stalled output handshake
    clear_prog();
    rom[0] = ins(7, 1, 0); rom[1] = ins(1, 1, 1); rom[2] = ins(7, 0, 0);
    rom[3] = ins(6, 0, 0); rom[4] = ins(15, 0, 0);
    in_vals[0] = 8'hFF; in_vals[1] = 8'hA5; out_dly[0] = 1000;
    model();
    do_reset("rstmid");
    p = 0;
    while (p < 100 && !out_valid) begin @(negedge clk); p++; end
    check("rstmid/reach_out", out_valid, 1);
    check("rstmid/carry_set", flag_c, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid/outv", out_valid, 0);
    check("rstmid/outd", out_data, 0);
    check("rstmid/pc", imem_addr, 0);
    check("rstmid/halt", halted, 0);
    check("rstmid/flags", {flag_z, flag_c}, 0);
    clear_prog();
    for (int i = 0; i < 4; i++) rom[i] = ins(6, i, 0);
    model();
    @(negedge clk); rst = 1'b0;
    run_body("rstmid_regs");

    // 0xFF + 0x01 through the input port
    clear_prog();
    rom[0] = ins(7, 0, 0); rom[1] = ins(7, 1, 0); rom[2] = ins(1, 0, 1); rom[3] = ins(6, 0, 0);
    in_vals[0] = 8'hFF; in_vals[1] = 8'h01;
    run_prog("add_wrap");
    check("add_wrap/z_c", {flag_z, flag_c}, 2'b11);

`ifdef ALU_SEQ_LDI_EN
    clear_prog();
    rom[0] = ins(11, 0, 0); rom[1] = 8'hFF; rom[2] = ins(11, 1, 0); rom[3] = 8'h01;
    rom[4] = ins(1, 0, 1); rom[5] = ins(6, 0, 0);
    run_prog("ldi_add");
    check("ldi_add/z_c", {flag_z, flag_c}, 2'b11);
`endif

    // jz taken (Z=1) and not taken (Z=0); taken path does a late input
    for (int t = 0; t < 2; t++) begin
      clear_prog();
      rom[0] = ins(7, 2, 0); rom[1] = ins(7, 3, 0);
      rom[2] = (t == 0) ? ins(2, 2, 2) : ins(1, 2, 3);
      rom[3] = ins(9, 0, 3); rom[4] = ins(6, 2, 0);
      rom[8'h40] = ins(7, 1, 0); rom[8'h41] = ins(6, 1, 0);
      in_vals[0] = 8'h05; in_vals[1] = 8'h40; in_vals[2] = 8'h3C; in_dly[2] = 5;
      run_prog((t == 0) ? "jz_taken" : "jz_fall");
    end

    // Output stalled four cycles
    clear_prog();
    rom[0] = ins(7, 0, 0); rom[1] = ins(6, 0, 0);
    in_vals[0] = 8'hA5; out_dly[0] = 4;
    run_prog("out_stall");

    // jmp to 0xFF, nop there, wrap to 0x00 where jz now branches away
    clear_prog();
    rom[0] = ins(9, 0, 3); rom[1] = ins(7, 3, 0); rom[2] = ins(7, 2, 0);
    rom[3] = ins(2, 0, 0); rom[4] = ins(10, 0, 2); rom[8'hFF] = 8'h00;
    rom[8'h50] = ins(6, 3, 0);
    in_vals[0] = 8'h50; in_vals[1] = 8'hFF;
    run_prog("jmp_wrap");

    // Random straight-line programs
    for (int k = 0; k < 6; k++) begin
      int ops [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 11, 12, 13, 14};
      int op;
      clear_prog();
      p = 0;
      for (int j = 0; j < 12; j++) begin
        op = ops[$urandom_range(0, 12)];
        rom[p] = ins(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3))); p++;
`ifdef ALU_SEQ_LDI_EN
        if (op == 11) begin rom[p] = 8'($urandom); p++; end
`endif
      end
      for (int i = 0; i < 4; i++) begin rom[p] = ins(6, i, 0); p++; end
      for (int i = 0; i < 32; i++) begin
        in_vals[i] = 8'($urandom); in_dly[i] = int'($urandom_range(0, 3));
        out_dly[i] = int'($urandom_range(0, 3));
      end
      run_prog("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
